// File: rtl/brownout_ctrl.sv
// ---------------------------------------------------------------------------
// brownout_ctrl
//
// Digital supervisor for the brownout detector macro (dvdd clock domain).
// Programs the detector enable and trip trims, masks the detector outputs
// while the analog front end settles and after every trim change,
// synchronizes the asynchronous detector outputs, and turns brownout events
// into a held system reset request, sticky interrupt flags and a saturating
// event counter.
//
// Ports:
//   clk, resetb              clock and asynchronous active-low reset
//   cfg_wr/ena/otrip/vtrip   configuration write (one-cycle pulse) + payload
//   cfg_busy, cfg_err        write would be dropped / sticky dropped-write flag
//   bo_ena/otrip/vtrip       detector configuration outputs
//   bo_out/vunder/timed_out  raw asynchronous detector outputs
//   sys_rst_n                active-low system reset request
//   irq_brout, irq_vunder    sticky interrupt flags
//   clr                      one-cycle pulse clearing cfg_err, irqs, ev_count
//   ev_count                 saturating brownout event count
//   armed                    detector outputs are being acted on
// ---------------------------------------------------------------------------
module brownout_ctrl #(
  parameter int SETTLE_CYCLES = 64,
  parameter int BLANK_CYCLES  = 16,
  parameter int HOLD_CYCLES   = 256,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       cfg_wr,
  input  logic       cfg_ena,
  input  logic [2:0] cfg_otrip,
  input  logic [2:0] cfg_vtrip,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic       bo_ena,
  output logic [2:0] bo_otrip,
  output logic [2:0] bo_vtrip,
  input  logic       bo_out,
  input  logic       bo_vunder,
  input  logic       bo_timed_out,
  output logic       sys_rst_n,
  output logic       irq_brout,
  output logic       irq_vunder,
  input  logic       clr,
  output logic [7:0] ev_count,
  output logic       armed
);

  localparam int MAX_A = (SETTLE_CYCLES > BLANK_CYCLES) ? SETTLE_CYCLES : BLANK_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] BLANK_LOAD  = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_ARMED,
    ST_BLANK,
    ST_TRIP,
    ST_HOLD
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizers: raw detector outputs are sampled only here.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] out_sync_q;
  logic [SYNC_STAGES-1:0] vun_sync_q;
  logic [SYNC_STAGES-1:0] to_sync_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_sync_q <= '0;
      vun_sync_q <= '0;
      to_sync_q  <= '0;
    end else begin
      out_sync_q <= {out_sync_q[SYNC_STAGES-2:0], bo_out};
      vun_sync_q <= {vun_sync_q[SYNC_STAGES-2:0], bo_vunder};
      to_sync_q  <= {to_sync_q[SYNC_STAGES-2:0], bo_timed_out};
    end
  end

  logic s_out, s_vun, s_to;
  assign s_out = out_sync_q[SYNC_STAGES-1];
  assign s_vun = vun_sync_q[SYNC_STAGES-1];
  assign s_to  = to_sync_q[SYNC_STAGES-1];

  // A detector timeout is treated as a brownout.
  logic ev;
  assign ev = s_out | s_to;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ev_prev_q, ev_prev_d;
  logic          bo_ena_q, bo_ena_d;
  logic [2:0]    otrip_q, otrip_d;
  logic [2:0]    vtrip_q, vtrip_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          irq_brout_q, irq_brout_d;
  logic          irq_vun_q, irq_vun_d;
  logic          cfg_err_q, cfg_err_d;
  logic [7:0]    ev_count_q, ev_count_d;
  logic          cfg_busy_q, cfg_busy_d;
  logic          armed_q, armed_d;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      ev_prev_q   <= 1'b0;
      bo_ena_q    <= 1'b0;
      otrip_q     <= 3'd0;
      vtrip_q     <= 3'd0;
      sys_rst_n_q <= 1'b1;
      irq_brout_q <= 1'b0;
      irq_vun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      ev_count_q  <= 8'd0;
      cfg_busy_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ev_prev_q   <= ev_prev_d;
      bo_ena_q    <= bo_ena_d;
      otrip_q     <= otrip_d;
      vtrip_q     <= vtrip_d;
      sys_rst_n_q <= sys_rst_n_d;
      irq_brout_q <= irq_brout_d;
      irq_vun_q   <= irq_vun_d;
      cfg_err_q   <= cfg_err_d;
      ev_count_q  <= ev_count_d;
      cfg_busy_q  <= cfg_busy_d;
      armed_q     <= armed_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  logic       ev_rise;
  logic       busy_now;
  logic       ev_inc;
  logic       err_set;
  logic [7:0] ev_base;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bo_ena_d    = bo_ena_q;
    otrip_d     = otrip_q;
    vtrip_d     = vtrip_q;
    sys_rst_n_d = sys_rst_n_q;
    ev_inc      = 1'b0;
    err_set     = 1'b0;
    ev_base     = 8'd0;

    // Reference is only live in ARMED, so an event that is already high when
    // ARMED is entered registers as a fresh rising edge.
    ev_rise   = ev & ~ev_prev_q;
    ev_prev_d = (state_q == ST_ARMED) ? ev : 1'b0;

    busy_now = (state_q == ST_SETTLE) || (state_q == ST_BLANK) ||
               (state_q == ST_TRIP)   || (state_q == ST_HOLD);

    case (state_q)
      ST_OFF: begin
        if (cfg_wr) begin
          otrip_d = cfg_otrip;
          vtrip_d = cfg_vtrip;
          if (cfg_ena) begin
            bo_ena_d = 1'b1;
            cnt_d    = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_ARMED: begin
        if (ev_rise) begin
          state_d     = ST_TRIP;
          sys_rst_n_d = 1'b0;
          ev_inc      = 1'b1;
          // A write colliding with a trip is lost, so report it.
          if (cfg_wr) begin
            err_set = 1'b1;
          end
        end else if (cfg_wr) begin
          if (cfg_ena) begin
            otrip_d = cfg_otrip;
            vtrip_d = cfg_vtrip;
            cnt_d   = BLANK_LOAD;
            state_d = ST_BLANK;
          end else begin
            bo_ena_d = 1'b0;
            state_d  = ST_OFF;
          end
        end
      end

      ST_BLANK: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_TRIP: begin
        sys_rst_n_d = 1'b0;
        if (!ev) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        sys_rst_n_d = 1'b0;
        if (ev) begin
          // Re-trigger: same brownout episode, not a new event.
          cnt_d   = HOLD_LOAD;
          state_d = ST_TRIP;
        end else if (cnt_q <= CNT_ONE) begin
          sys_rst_n_d = 1'b1;
          state_d     = ST_ARMED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d     = ST_OFF;
        bo_ena_d    = 1'b0;
        sys_rst_n_d = 1'b1;
      end
    endcase

    if (cfg_wr && busy_now) begin
      err_set = 1'b1;
    end

    // Sticky flags: a set in the same cycle as clr wins.
    irq_brout_d = ev_inc | (irq_brout_q & ~clr);
    irq_vun_d   = ((state_q == ST_ARMED) & s_vun) | (irq_vun_q & ~clr);
    cfg_err_d   = err_set | (cfg_err_q & ~clr);

    ev_base    = clr ? 8'd0 : ev_count_q;
    ev_count_d = (ev_inc && (ev_base != 8'hFF)) ? (ev_base + 8'd1) : ev_base;

    cfg_busy_d = (state_d == ST_SETTLE) || (state_d == ST_BLANK) ||
                 (state_d == ST_TRIP)   || (state_d == ST_HOLD);
    armed_d    = (state_d == ST_ARMED);
  end

  assign cfg_busy   = cfg_busy_q;
  assign cfg_err    = cfg_err_q;
  assign bo_ena     = bo_ena_q;
  assign bo_otrip   = otrip_q;
  assign bo_vtrip   = vtrip_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign irq_brout  = irq_brout_q;
  assign irq_vunder = irq_vun_q;
  assign ev_count   = ev_count_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_brownout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_brownout_ctrl
//
// Directed bench for brownout_ctrl with default parameters. Inputs are driven
// and outputs sampled on the falling clock edge; expected values are derived
// by hand from the edge-level timing of the controller.
// ---------------------------------------------------------------------------
module tb_brownout_ctrl;

  logic       clk;
  logic       resetb;
  logic       cfg_wr;
  logic       cfg_ena;
  logic [2:0] cfg_otrip;
  logic [2:0] cfg_vtrip;
  logic       cfg_busy;
  logic       cfg_err;
  logic       bo_ena;
  logic [2:0] bo_otrip;
  logic [2:0] bo_vtrip;
  logic       bo_out;
  logic       bo_vunder;
  logic       bo_timed_out;
  logic       sys_rst_n;
  logic       irq_brout;
  logic       irq_vunder;
  logic       clr;
  logic [7:0] ev_count;
  logic       armed;

  int total;
  int bad;

  brownout_ctrl #(
    .SETTLE_CYCLES(64),
    .BLANK_CYCLES (16),
    .HOLD_CYCLES  (256),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .cfg_wr      (cfg_wr),
    .cfg_ena     (cfg_ena),
    .cfg_otrip   (cfg_otrip),
    .cfg_vtrip   (cfg_vtrip),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .bo_ena      (bo_ena),
    .bo_otrip    (bo_otrip),
    .bo_vtrip    (bo_vtrip),
    .bo_out      (bo_out),
    .bo_vunder   (bo_vunder),
    .bo_timed_out(bo_timed_out),
    .sys_rst_n   (sys_rst_n),
    .irq_brout   (irq_brout),
    .irq_vunder  (irq_vunder),
    .clr         (clr),
    .ev_count    (ev_count),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    #1;
    total++;
    if (sys_rst_n !== 1'b1 || bo_ena !== 1'b0 || bo_otrip !== 3'd0 || bo_vtrip !== 3'd0 ||
        irq_brout !== 1'b0 || irq_vunder !== 1'b0 || cfg_err !== 1'b0 || ev_count !== 8'd0 ||
        cfg_busy !== 1'b0 || armed !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got rst_n=%b ena=%b ot=%0d vt=%0d irq=%b%b err=%b cnt=%0d busy=%b armed=%b, want 1 0 0 0 00 0 0 0 0",
               sys_rst_n, bo_ena, bo_otrip, bo_vtrip, irq_brout, irq_vunder, cfg_err, ev_count, cfg_busy, armed);
    end
    step(3);
    resetb = 1'b1;
    step(2);
    $display("test_reset done");
  endtask

  task automatic test_enable();
    cfg_wr = 1'b1; cfg_ena = 1'b1; cfg_otrip = 3'd5; cfg_vtrip = 3'd3;
    step(1);
    cfg_wr = 1'b0;
    total++;
    if (bo_ena !== 1'b1 || bo_otrip !== 3'd5 || bo_vtrip !== 3'd3 || cfg_busy !== 1'b1 || armed !== 1'b0) begin
      bad++;
      $display("FAIL enable_apply: got ena=%b ot=%0d vt=%0d busy=%b armed=%b, want 1 5 3 1 0",
               bo_ena, bo_otrip, bo_vtrip, cfg_busy, armed);
    end
    for (int k = 1; k <= 63; k++) begin
      step(1);
      if (k == 10) bo_out = 1'b1;
      if (k == 20) bo_out = 1'b0;
    end
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL settle_early: armed=%b at edge 63 after apply, want 0", armed);
    end
    step(1);
    total++;
    if (armed !== 1'b1 || cfg_busy !== 1'b0 || irq_brout !== 1'b0 || sys_rst_n !== 1'b1 || ev_count !== 8'd0) begin
      bad++;
      $display("FAIL settle_done: got armed=%b busy=%b irq=%b rst_n=%b cnt=%0d, want 1 0 0 1 0",
               armed, cfg_busy, irq_brout, sys_rst_n, ev_count);
    end
    $display("test_enable done");
  endtask

  task automatic test_pulse();
    bo_out = 1'b1;
    step(2);
    total++;
    if (sys_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL trip_early: sys_rst_n=%b at +2 edges, want 1", sys_rst_n);
    end
    step(1);
    total++;
    if (sys_rst_n !== 1'b0 || irq_brout !== 1'b1 || ev_count !== 8'd1 || armed !== 1'b0 || cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL trip_edge: got rst_n=%b irq=%b cnt=%0d armed=%b busy=%b, want 0 1 1 0 1",
               sys_rst_n, irq_brout, ev_count, armed, cfg_busy);
    end
    step(7);
    bo_out = 1'b0;
    step(258);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL hold_early: sys_rst_n=%b at fall+258, want 0", sys_rst_n);
    end
    step(1);
    total++;
    if (sys_rst_n !== 1'b1 || armed !== 1'b1 || ev_count !== 8'd1) begin
      bad++;
      $display("FAIL hold_release: got rst_n=%b armed=%b cnt=%0d at fall+259, want 1 1 1",
               sys_rst_n, armed, ev_count);
    end
    $display("test_pulse done");
  endtask

  task automatic test_retrigger();
    bo_out = 1'b1;
    step(1);
    bo_out = 1'b0;
    step(2);
    total++;
    if (sys_rst_n !== 1'b0 || ev_count !== 8'd2) begin
      bad++;
      $display("FAIL retrig_trip: got rst_n=%b cnt=%0d, want 0 2", sys_rst_n, ev_count);
    end
    // HOLD entered at edge 4; its counter reads 100 at edge 160.
    step(154);
    bo_out = 1'b1;
    step(1);
    bo_out = 1'b0;
    step(2);
    total++;
    if (sys_rst_n !== 1'b0 || ev_count !== 8'd2) begin
      bad++;
      $display("FAIL retrig_hold: got rst_n=%b cnt=%0d, want 0 2", sys_rst_n, ev_count);
    end
    step(140);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL retrig_restart: sys_rst_n=%b at edge 300, want 0", sys_rst_n);
    end
    step(116);
    total++;
    if (sys_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL retrig_early: sys_rst_n=%b at edge 416, want 0", sys_rst_n);
    end
    step(1);
    total++;
    if (sys_rst_n !== 1'b1 || armed !== 1'b1 || ev_count !== 8'd2) begin
      bad++;
      $display("FAIL retrig_release: got rst_n=%b armed=%b cnt=%0d at edge 417, want 1 1 2",
               sys_rst_n, armed, ev_count);
    end
    $display("test_retrigger done");
  endtask

  task automatic test_vunder();
    bo_vunder = 1'b1;
    step(2);
    total++;
    if (irq_vunder !== 1'b0) begin
      bad++;
      $display("FAIL vunder_early: irq_vunder=%b at +2, want 0", irq_vunder);
    end
    step(1);
    total++;
    if (irq_vunder !== 1'b1 || sys_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL vunder_set: got irq_vunder=%b rst_n=%b, want 1 1", irq_vunder, sys_rst_n);
    end
    bo_vunder = 1'b0;
    step(5);
    total++;
    if (irq_vunder !== 1'b1) begin
      bad++;
      $display("FAIL vunder_sticky: irq_vunder=%b, want 1", irq_vunder);
    end
    $display("test_vunder done");
  endtask

  task automatic test_blank();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++;
    if (irq_brout !== 1'b0 || irq_vunder !== 1'b0 || ev_count !== 8'd0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL clr_all: got irq=%b%b cnt=%0d err=%b, want 00 0 0",
               irq_brout, irq_vunder, ev_count, cfg_err);
    end
    cfg_wr = 1'b1; cfg_ena = 1'b1; cfg_otrip = 3'd2; cfg_vtrip = 3'd3;
    step(1);
    cfg_wr = 1'b0;
    total++;
    if (bo_otrip !== 3'd2 || bo_vtrip !== 3'd3 || cfg_busy !== 1'b1 || armed !== 1'b0 || bo_ena !== 1'b1) begin
      bad++;
      $display("FAIL blank_apply: got ot=%0d vt=%0d busy=%b armed=%b ena=%b, want 2 3 1 0 1",
               bo_otrip, bo_vtrip, cfg_busy, armed, bo_ena);
    end
    step(2);
    bo_out = 1'b1;
    step(2);
    bo_out = 1'b0;
    step(3);
    cfg_wr = 1'b1; cfg_otrip = 3'd7;
    step(1);
    cfg_wr = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || bo_otrip !== 3'd2) begin
      bad++;
      $display("FAIL blank_drop: got err=%b ot=%0d, want 1 2", cfg_err, bo_otrip);
    end
    step(7);
    total++;
    if (armed !== 1'b0) begin
      bad++;
      $display("FAIL blank_early: armed=%b at edge 16, want 0", armed);
    end
    step(1);
    total++;
    if (armed !== 1'b1 || irq_brout !== 1'b0 || ev_count !== 8'd0 || sys_rst_n !== 1'b1 || cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL blank_done: got armed=%b irq=%b cnt=%0d rst_n=%b err=%b, want 1 0 0 1 1",
               armed, irq_brout, ev_count, sys_rst_n, cfg_err);
    end
    $display("test_blank done");
  endtask

  task automatic test_saturate();
    int timeouts;
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      int n;
      bo_out = 1'b1;
      step(1);
      bo_out = 1'b0;
      n = 0;
      while (sys_rst_n !== 1'b0 && n < 20) begin step(1); n++; end
      if (sys_rst_n !== 1'b0) timeouts++;
      n = 0;
      while (sys_rst_n !== 1'b1 && n < 400) begin step(1); n++; end
      if (sys_rst_n !== 1'b1) timeouts++;
      if (i == 254) begin
        total++;
        if (ev_count !== 8'd255) begin
          bad++;
          $display("FAIL sat_255: ev_count=%0d after 255 events, want 255", ev_count);
        end
      end
    end
    total++;
    if (timeouts != 0) begin
      bad++;
      $display("FAIL sat_timeouts: %0d waits expired, want 0", timeouts);
    end
    total++;
    if (ev_count !== 8'd255 || irq_brout !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: got cnt=%0d irq=%b after 256 events, want 255 1", ev_count, irq_brout);
    end
    $display("test_saturate done");
  endtask

  task automatic test_clr_coincident();
    int n;
    bo_out = 1'b1;
    step(1);
    bo_out = 1'b0;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++;
    if (ev_count !== 8'd1 || irq_brout !== 1'b1 || sys_rst_n !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL clr_coincident: got cnt=%0d irq=%b rst_n=%b err=%b, want 1 1 0 0",
               ev_count, irq_brout, sys_rst_n, cfg_err);
    end
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 400) begin step(1); n++; end
    total++;
    if (sys_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL clr_release: sys_rst_n=%b after 400 cycles, want 1", sys_rst_n);
    end
    $display("test_clr_coincident done");
  endtask

  task automatic test_reset_in_hold();
    bo_out = 1'b1;
    step(1);
    bo_out = 1'b0;
    step(5);
    total++;
    if (sys_rst_n !== 1'b0 || irq_brout !== 1'b1) begin
      bad++;
      $display("FAIL hold_pre: got rst_n=%b irq=%b, want 0 1", sys_rst_n, irq_brout);
    end
    #2;
    resetb = 1'b0;
    #1;
    total++;
    if (sys_rst_n !== 1'b1 || bo_ena !== 1'b0 || bo_otrip !== 3'd0 || irq_brout !== 1'b0 ||
        irq_vunder !== 1'b0 || ev_count !== 8'd0 || cfg_err !== 1'b0 || armed !== 1'b0 || cfg_busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got rst_n=%b ena=%b ot=%0d irq=%b%b cnt=%0d err=%b armed=%b busy=%b, want 1 0 0 00 0 0 0 0",
               sys_rst_n, bo_ena, bo_otrip, irq_brout, irq_vunder, ev_count, cfg_err, armed, cfg_busy);
    end
    step(2);
    resetb = 1'b1;
    step(2);
    $display("test_reset_in_hold done");
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetb = 1'b0;
    cfg_wr = 1'b0; cfg_ena = 1'b0; cfg_otrip = 3'd0; cfg_vtrip = 3'd0;
    bo_out = 1'b0; bo_vunder = 1'b0; bo_timed_out = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_enable();
    test_pulse();
    test_retrigger();
    test_vunder();
    test_blank();
    test_saturate();
    test_clr_coincident();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
